// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - one-hot CPU phase sequencer with run/step/drain control
// A programmable divider sets the phase period; stall holds only the terminal count cycle.
module phase_sequencer #(
  parameter int PHASES      = 5,
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 1000
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  input  logic              stall,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_value,
  output logic [PHASES-1:0] phase,
  output logic              phase_tick,
  output logic              instr_done,
  output logic              busy,
  output logic [31:0]       instr_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DIV_W-1:0]  r_cnt;
  logic [DIV_W-1:0]  r_div;
  logic [PHASES-1:0] r_phase;
  logic [31:0]       r_count;

  logic w_active;
  logic w_term;
  logic w_quit;
  logic w_adv;
  logic w_wrap;

  assign w_active = (r_state != S_IDLE);
  assign w_term   = (r_cnt == r_div);
  // Run dropped exactly on an instruction boundary: stop without starting the next instruction.
  assign w_quit   = (r_state == S_RUN) && !run && r_phase[0] && (r_cnt == '0);
  assign w_adv    = w_active && w_term && !stall && !w_quit;
  assign w_wrap   = w_adv && r_phase[PHASES-1];

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_state_next = S_RUN;
        end else if (step) begin
          w_state_next = S_STEP;
        end
      end
      S_RUN: begin
        if (!run) begin
          w_state_next = (w_wrap || w_quit) ? S_IDLE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (run) begin
          w_state_next = S_RUN;
        end else if (w_wrap) begin
          w_state_next = S_IDLE;
        end
      end
      S_STEP: begin
        if (w_wrap) begin
          w_state_next = run ? S_RUN : S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    phase_tick = 1'b0;
    instr_done = 1'b0;
    if (w_active) begin
      busy       = 1'b1;
      phase_tick = w_adv;
      instr_done = w_wrap;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= PHASES'(1);
      r_div   <= DIV_W'(DIV_DEFAULT);
      r_count <= '0;
    end else begin
      if (w_state_next == S_IDLE) begin
        r_cnt   <= '0;
        r_phase <= PHASES'(1);
      end else if (w_active) begin
        if (!w_term) begin
          r_cnt <= r_cnt + DIV_W'(1);
        end else if (w_adv) begin
          r_cnt   <= '0;
          r_phase <= {r_phase[PHASES-2:0], r_phase[PHASES-1]};
        end
      end
      if ((r_state == S_IDLE) && div_load) begin
        r_div <= div_value;
      end
      if (w_wrap) begin
        r_count <= r_count + 32'd1;
      end
    end
  end

  assign phase       = r_phase;
  assign instr_count = r_count;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - scoreboard bench for phase_sequencer
module tb_phase_sequencer;

  localparam int P      = 5;
  localparam int DW     = 16;
  localparam int DDEF   = 1000;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_STEP  = 2;
  localparam int M_DRAIN = 3;

  logic          clk_in;
  logic          rst_n;
  logic          run;
  logic          step;
  logic          stall;
  logic          div_load;
  logic [DW-1:0] div_value;
  logic [P-1:0]  phase;
  logic          phase_tick;
  logic          instr_done;
  logic          busy;
  logic [31:0]   instr_count;

  phase_sequencer #(.PHASES(P), .DIV_W(DW), .DIV_DEFAULT(DDEF)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .run         (run),
    .step        (step),
    .stall       (stall),
    .div_load    (div_load),
    .div_value   (div_value),
    .phase       (phase),
    .phase_tick  (phase_tick),
    .instr_done  (instr_done),
    .busy        (busy),
    .instr_count (instr_count)
  );

  typedef struct {
    int          cyc;
    logic [P-1:0] ph;
    logic        done;
    logic [31:0] cnt;
  } exp_t;

  exp_t         q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           m_mode, m_ph, m_cnt, m_div;
  logic [31:0]  m_count;
  logic         cur_busy;
  logic [P-1:0] cur_phase;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: cycle %0d got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: mode, phase index and in-phase count advanced once per cycle.
  initial begin : model
    bit quit, adv, wrap;
    int nmode;
    forever begin
      @(negedge clk_in);
      if (!rst_n) begin
        m_mode = M_IDLE; m_ph = 0; m_cnt = 0; m_div = DDEF; m_count = 0;
        cur_busy = 1'b0; cur_phase = P'(1);
      end else begin
        cur_busy  = (m_mode != M_IDLE);
        cur_phase = P'(1) << m_ph;
        quit = (m_mode == M_RUN) && !run && (m_ph == 0) && (m_cnt == 0);
        adv  = cur_busy && (m_cnt == m_div) && !stall && !quit;
        wrap = adv && (m_ph == P - 1);
        if (adv) q.push_back(exp_t'{cyc, cur_phase, wrap, m_count});
        nmode = m_mode;
        case (m_mode)
          M_IDLE: begin
            if (div_load) m_div = int'(div_value);
            if (run) nmode = M_RUN;
            else if (step) nmode = M_STEP;
          end
          M_RUN:   if (!run) nmode = (wrap || quit) ? M_IDLE : M_DRAIN;
          M_DRAIN: if (run) nmode = M_RUN; else if (wrap) nmode = M_IDLE;
          default: if (wrap) nmode = run ? M_RUN : M_IDLE;
        endcase
        if (cur_busy) begin
          if (m_cnt < m_div) m_cnt++;
          else if (adv) begin
            m_cnt = 0;
            m_ph  = (m_ph + 1) % P;
          end
        end
        if (wrap) m_count++;
        m_mode = nmode;
        if (m_mode == M_IDLE) begin
          m_ph = 0; m_cnt = 0;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_in);
      #1;
      chk("phase", 64'(phase), 64'(cur_phase));
      chk("busy", 64'(busy), 64'(cur_busy));
      while (q.size() > 0 && q[0].cyc < cyc) begin
        total++; bad++;
        $display("FAIL missed_tick: cycle %0d got none want tick at cycle %0d", cyc, q[0].cyc);
        e = q.pop_front();
      end
      if (phase_tick) begin
        if (q.size() == 0 || q[0].cyc != cyc) begin
          total++; bad++;
          $display("FAIL extra_tick: cycle %0d got tick want none", cyc);
        end else begin
          e = q.pop_front();
          chk("tick_phase", 64'(phase), 64'(e.ph));
          chk("instr_done", 64'(instr_done), 64'(e.done));
          chk("instr_count", 64'(instr_count), 64'(e.cnt));
        end
      end else begin
        chk("done_without_tick", 64'(instr_done), 64'd0);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic wait_phase(input logic [P-1:0] p, input int lim);
    int k = 0;
    while (phase !== p && k < lim) begin
      cycles(1);
      k++;
    end
    chk("wait_phase", 64'(phase), 64'(p));
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    while (busy !== 1'b0 && k < lim) begin
      cycles(1);
      k++;
    end
    chk("wait_idle", 64'(busy), 64'd0);
  endtask

  task automatic load_div(input int v);
    div_value = DW'(v);
    div_load  = 1'b1;
    cycles(1);
    div_load  = 1'b0;
  endtask

  initial begin : stim
    int k;
    rst_n = 1'b0; run = 1'b0; step = 1'b0; stall = 1'b0;
    div_load = 1'b0; div_value = '0;
    cycles(3);
    chk("rst_phase", 64'(phase), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tick", 64'(phase_tick), 64'd0);
    chk("rst_done", 64'(instr_done), 64'd0);
    chk("rst_count", 64'(instr_count), 64'd0);
    rst_n = 1'b1;
    cycles(5);
    chk("no_adv_after_reset", 64'(phase), 64'd1);

    // Period 4, one instruction per 20 cycles.
    load_div(3);
    run = 1'b1;
    cycles(21);
    chk("count_after_20", 64'(instr_count), 64'd1);
    run = 1'b0;
    cycles(2);
    chk("idle_after_run", 64'(busy), 64'd0);

    // Single step at full speed; a second step while busy is ignored.
    load_div(0);
    step = 1'b1; cycles(1); step = 1'b0;
    cycles(2);
    step = 1'b1; cycles(1); step = 1'b0;
    cycles(6);
    chk("step_phase", 64'(phase), 64'd1);
    chk("step_busy", 64'(busy), 64'd0);
    chk("step_count", 64'(instr_count), 64'd2);

    // Stall at the terminal count of phase bit 1.
    load_div(2);
    run = 1'b1;
    wait_phase(5'b00010, 20);
    cycles(2);
    stall = 1'b1; cycles(5); stall = 1'b0;
    cycles(20);

    // Drain from phase bit 2, then a drain interrupted by run.
    wait_phase(5'b00100, 30);
    run = 1'b0;
    wait_idle(40);
    chk("drain_phase", 64'(phase), 64'd1);
    run = 1'b1;
    wait_phase(5'b00100, 30);
    run = 1'b0;
    cycles(2);
    run = 1'b1;
    cycles(15);

    // Divider load ignored while running, honoured in idle.
    load_div(7);
    cycles(15);
    run = 1'b0;
    wait_idle(40);
    load_div(7);
    run = 1'b1;
    cycles(45);
    run = 1'b0;
    wait_idle(60);

    // Randomized control traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) run = ~run;
      step      = ($urandom_range(0, 7) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      div_load  = ($urandom_range(0, 7) == 0);
      div_value = DW'($urandom_range(0, 3));
      rst_n     = ($urandom_range(0, 499) != 0);
      cycles(1);
    end
    rst_n = 1'b1; run = 1'b0; step = 1'b0; stall = 1'b0; div_load = 1'b0;
    wait_idle(6000);

    // Reset mid-instruction discards it and restores the default divider.
    rst_n = 1'b0; cycles(1); rst_n = 1'b1;
    load_div(0);
    run = 1'b1;
    k = 0;
    while (!(instr_count == 32'd5 && phase == 5'b01000) && k < 100) begin
      cycles(1);
      k++;
    end
    chk("pre_reset_phase", 64'(phase), 64'h8);
    chk("pre_reset_count", 64'(instr_count), 64'd5);
    rst_n = 1'b0;
    #1;
    chk("async_rst_phase", 64'(phase), 64'd1);
    chk("async_rst_count", 64'(instr_count), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_tick", 64'(phase_tick), 64'd0);
    chk("async_rst_done", 64'(instr_done), 64'd0);
    cycles(1);
    rst_n = 1'b1;
    cycles(1010);
    chk("default_div_phase", 64'(phase), 64'h2);
    run = 1'b0;
    wait_idle(6000);
    cycles(3);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
